// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit constants: RUN/HALT state encoding and the default
// sequence-counter geometry.
package cpu_ctrl_pkg;

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   localparam int DEF_CNT_W  = 3;
   localparam int DEF_LAST_T = 7;

endpackage

// File: rtl/seq_onehot_dec.sv
// Binary-to-one-hot decoder. Also used by the opcode decoder.
module seq_onehot_dec #(
   parameter  int SEL_W = 3,
   localparam int OUT_W = 2**SEL_W
) (
   input  logic [SEL_W-1:0] sel_i,
   output logic [OUT_W-1:0] onehot_o
);

   for (genvar i = 0; i < OUT_W; i++) begin : g_bit
      assign onehot_o[i] = (sel_i == SEL_W'(i));
   end

endmodule

// File: rtl/seq_timing_gen.sv
// Sequence counter and T-state generator with a RUN/HALT FSM.
// Supports HLT, single-step, clear and load.
module seq_timing_gen
   import cpu_ctrl_pkg::*;
#(
   parameter  int CNT_W  = DEF_CNT_W,
   parameter  int LAST_T = DEF_LAST_T,
   localparam int NT     = 2**CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             step_en,
   input  logic             load_en,
   input  logic [CNT_W-1:0] load_val,
   input  logic             halt,
   input  logic             resume,
   input  logic             single,
   output logic [CNT_W-1:0] sc_out,
   output logic [NT-1:0]    t_out,
   output logic             wrap,
   output logic             halted
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_T);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;
   logic [0:0]       state_q, state_d;
   logic             single_q;
   logic             inc;

   // While halted, only a rising edge of single advances the count.
   always_comb begin
      inc    = (state_q == ST_RUN) ? step_en : (single & ~single_q);
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (load_en) begin
         cnt_d = (load_val > LAST_CNT) ? LAST_CNT : load_val;
      end else if (inc) begin
         if (cnt_q == LAST_CNT) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // halt wins over resume in either state.
   always_comb begin
      state_d = state_q;
      if (state_q == ST_RUN) begin
         if (halt) state_d = ST_HALT;
      end else if (resume && !halt) begin
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         wrap_q   <= 1'b0;
         state_q  <= ST_RUN;
         single_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         wrap_q   <= wrap_d;
         state_q  <= state_d;
         single_q <= single;
      end
   end

   assign sc_out = cnt_q;
   assign wrap   = wrap_q;
   assign halted = (state_q == ST_HALT);

   seq_onehot_dec #(.SEL_W(CNT_W)) u_dec (
      .sel_i    (cnt_q),
      .onehot_o (t_out)
   );

endmodule
